// File: rtl/ysyx_23060236_rd_arbiter_pkg.sv
// Shared definitions for the read-channel arbiter: CLINT decode window,
// state encodings and the address decode used by every arbiter on the bus.
package ysyx_23060236_rd_arbiter_pkg;

  localparam logic [31:0] CLINT_BASE = 32'h0200_0000;
  localparam logic [31:0] CLINT_MASK = 32'hFFFF_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  typedef enum logic {
    REQ_IFU = 1'b0,
    REQ_LSU = 1'b1
  } req_t;

  typedef enum logic {
    TGT_MEM   = 1'b0,
    TGT_CLINT = 1'b1
  } tgt_t;

  // Kept as one expression so a future write arbiter decodes identically.
  function automatic logic addr_hits(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/ysyx_23060236_Reg.sv
// Generic register with synchronous active-high reset and write enable.
module ysyx_23060236_Reg #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wen,
  output logic [WIDTH-1:0] dout
);

  always_ff @(posedge clock) begin
    if (reset) begin
      dout <= RESET_VAL;
    end else if (wen) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/ysyx_23060236_rd_arbiter.sv
// Round-robin read arbiter: IFU/LSU requesters onto CLINT/mem slaves,
// one transaction in flight, unbuffered combinational response path.
module ysyx_23060236_rd_arbiter
  import ysyx_23060236_rd_arbiter_pkg::*;
#(
  parameter logic [31:0] CLINT_BASE = ysyx_23060236_rd_arbiter_pkg::CLINT_BASE,
  parameter logic [31:0] CLINT_MASK = ysyx_23060236_rd_arbiter_pkg::CLINT_MASK
) (
  input  logic        clock,
  input  logic        reset,

  input  logic [31:0] ifu_araddr,
  input  logic        ifu_arvalid,
  output logic        ifu_arready,
  output logic [31:0] ifu_rdata,
  output logic [1:0]  ifu_rresp,
  output logic        ifu_rvalid,
  input  logic        ifu_rready,

  input  logic [31:0] lsu_araddr,
  input  logic        lsu_arvalid,
  output logic        lsu_arready,
  output logic [31:0] lsu_rdata,
  output logic [1:0]  lsu_rresp,
  output logic        lsu_rvalid,
  input  logic        lsu_rready,

  output logic [31:0] clint_araddr,
  output logic        clint_arvalid,
  input  logic        clint_arready,
  input  logic [31:0] clint_rdata,
  input  logic [1:0]  clint_rresp,
  input  logic        clint_rvalid,
  output logic        clint_rready,

  output logic [31:0] mem_araddr,
  output logic        mem_arvalid,
  input  logic        mem_arready,
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  mem_rresp,
  input  logic        mem_rvalid,
  output logic        mem_rready
);

  logic [1:0]  state_q;
  state_t      state;
  state_t      state_nxt;
  logic        grant;
  logic        last_grant;
  logic        sel;
  logic [31:0] addr;

  logic        win_lsu;
  logic        accept;
  logic [31:0] win_addr;
  logic        win_clint;
  logic        in_addr;
  logic        in_data;
  logic        s_arready;
  logic        s_rvalid;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        g_rready;

  assign state = state_t'(state_q);

  // Tie goes to whoever did not win last time.
  assign win_lsu   = lsu_arvalid && (!ifu_arvalid || last_grant == REQ_IFU);
  assign accept    = !reset && state == IDLE && (ifu_arvalid || lsu_arvalid);
  assign win_addr  = win_lsu ? lsu_araddr : ifu_araddr;
  assign win_clint = addr_hits(win_addr, CLINT_BASE, CLINT_MASK);

  assign ifu_arready = accept && !win_lsu;
  assign lsu_arready = accept && win_lsu;

  assign in_addr = !reset && state == ADDR;
  assign in_data = !reset && state == DATA;

  assign clint_araddr  = addr;
  assign mem_araddr    = addr;
  assign clint_arvalid = in_addr && sel == TGT_CLINT;
  assign mem_arvalid   = in_addr && sel == TGT_MEM;

  assign s_arready = (sel == TGT_CLINT) ? clint_arready : mem_arready;
  assign s_rvalid  = (sel == TGT_CLINT) ? clint_rvalid  : mem_rvalid;
  assign s_rdata   = (sel == TGT_CLINT) ? clint_rdata   : mem_rdata;
  assign s_rresp   = (sel == TGT_CLINT) ? clint_rresp   : mem_rresp;
  assign g_rready  = (grant == REQ_LSU) ? lsu_rready    : ifu_rready;

  assign ifu_rdata  = s_rdata;
  assign ifu_rresp  = s_rresp;
  assign lsu_rdata  = s_rdata;
  assign lsu_rresp  = s_rresp;
  assign ifu_rvalid = in_data && grant == REQ_IFU && s_rvalid;
  assign lsu_rvalid = in_data && grant == REQ_LSU && s_rvalid;

  assign clint_rready = in_data && sel == TGT_CLINT && g_rready;
  assign mem_rready   = in_data && sel == TGT_MEM   && g_rready;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = ADDR;
      ADDR:    if (s_arready) state_nxt = DATA;
      DATA:    if (s_rvalid && g_rready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  ysyx_23060236_Reg #(.WIDTH(2), .RESET_VAL(2'(IDLE))) u_state (
    .clock(clock), .reset(reset), .din(2'(state_nxt)), .wen(1'b1), .dout(state_q)
  );

  ysyx_23060236_Reg #(.WIDTH(1), .RESET_VAL(1'b0)) u_grant (
    .clock(clock), .reset(reset), .din(win_lsu), .wen(accept), .dout(grant)
  );

  ysyx_23060236_Reg #(.WIDTH(1), .RESET_VAL(1'b0)) u_last_grant (
    .clock(clock), .reset(reset), .din(win_lsu), .wen(accept), .dout(last_grant)
  );

  ysyx_23060236_Reg #(.WIDTH(1), .RESET_VAL(1'b0)) u_sel (
    .clock(clock), .reset(reset), .din(win_clint), .wen(accept), .dout(sel)
  );

  ysyx_23060236_Reg #(.WIDTH(32), .RESET_VAL(32'h0)) u_addr (
    .clock(clock), .reset(reset), .din(win_addr), .wen(accept), .dout(addr)
  );

endmodule

// File: tb/tb_ysyx_23060236_rd_arbiter.sv
// Bench for the read arbiter: directed scenarios plus a random phase, all
// checked cycle by cycle against a transaction-level model.
module tb_ysyx_23060236_rd_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] ifu_araddr, lsu_araddr, clint_araddr, mem_araddr;
  logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
  logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
  logic [31:0] ifu_rdata, lsu_rdata, clint_rdata, mem_rdata;
  logic [1:0]  ifu_rresp, lsu_rresp, clint_rresp, mem_rresp;
  logic        clint_arvalid, clint_arready, clint_rvalid, clint_rready;
  logic        mem_arvalid, mem_arready, mem_rvalid, mem_rready;

  always #5 clock = ~clock;

  ysyx_23060236_rd_arbiter dut (
    .clock(clock), .reset(reset),
    .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
    .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
    .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
    .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
    .clint_araddr(clint_araddr), .clint_arvalid(clint_arvalid), .clint_arready(clint_arready),
    .clint_rdata(clint_rdata), .clint_rresp(clint_rresp), .clint_rvalid(clint_rvalid),
    .clint_rready(clint_rready),
    .mem_araddr(mem_araddr), .mem_arvalid(mem_arvalid), .mem_arready(mem_arready),
    .mem_rdata(mem_rdata), .mem_rresp(mem_rresp), .mem_rvalid(mem_rvalid), .mem_rready(mem_rready)
  );

  int checks = 0;
  int errors = 0;

  // Transaction-level model: the one in-flight read and who won last.
  bit          m_busy, m_ar_done, m_who, m_clint, m_last;
  logic [31:0] m_addr;

  int obs_resp[2];
  bit grant_log[$];
  bit saw_clint, saw_mem;
  bit rand_mode, keep_valid;

  function automatic bit hits_clint(input logic [31:0] a);
    return (a & 32'hFFFF_0000) == 32'h0200_0000;
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 5))
      0:       return 32'h0200_0000 | ($urandom & 32'h0000_FFFC);
      1:       return 32'h0201_0000;
      2:       return 32'h01FF_FFFC;
      3:       return 32'h0200_FFFC;
      default: return 32'h8000_0000 | ($urandom & 32'h07FF_FFFC);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit          winner, acc_ifu, acc_lsu, s_rvalid, g_rready;
    bit          e_carv, e_marv, e_irv, e_lrv, e_crr, e_mrr;
    bit          hs_ifu, hs_lsu;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    bit          n_busy, n_ar_done, n_who, n_clint, n_last;
    logic [31:0] n_addr;
    if (rand_mode) begin
      clint_arready = 1'($urandom_range(0, 1));
      mem_arready   = 1'($urandom_range(0, 1));
      clint_rvalid  = 1'($urandom_range(0, 1));
      mem_rvalid    = 1'($urandom_range(0, 1));
      ifu_rready    = 1'($urandom_range(0, 1));
      lsu_rready    = 1'($urandom_range(0, 1));
    end
    clint_rdata = $urandom;
    mem_rdata   = $urandom;
    clint_rresp = 2'($urandom_range(0, 3));
    mem_rresp   = 2'($urandom_range(0, 3));
    #1;
    {acc_ifu, acc_lsu, e_carv, e_marv, e_irv, e_lrv, e_crr, e_mrr} = '0;
    {n_busy, n_ar_done, n_who, n_clint, n_last, n_addr} =
      {m_busy, m_ar_done, m_who, m_clint, m_last, m_addr};
    if (reset) begin
      n_busy = 0;
      n_last = 0;
    end else if (!m_busy) begin
      if (ifu_arvalid || lsu_arvalid) begin
        winner  = (ifu_arvalid && lsu_arvalid) ? !m_last : lsu_arvalid;
        acc_ifu = !winner;
        acc_lsu = winner;
        n_busy = 1; n_ar_done = 0; n_who = winner; n_last = winner;
        n_addr  = winner ? lsu_araddr : ifu_araddr;
        n_clint = hits_clint(n_addr);
      end
    end else if (!m_ar_done) begin
      e_carv = m_clint;
      e_marv = !m_clint;
      chk("slave_araddr", m_clint ? clint_araddr : mem_araddr, m_addr);
      if (m_clint ? clint_arready : mem_arready) n_ar_done = 1;
    end else begin
      s_rvalid = m_clint ? clint_rvalid : mem_rvalid;
      s_rdata  = m_clint ? clint_rdata : mem_rdata;
      s_rresp  = m_clint ? clint_rresp : mem_rresp;
      g_rready = m_who ? lsu_rready : ifu_rready;
      e_irv = !m_who && s_rvalid;
      e_lrv = m_who && s_rvalid;
      e_crr = m_clint && g_rready;
      e_mrr = !m_clint && g_rready;
      if (s_rvalid) begin
        chk("rdata", m_who ? lsu_rdata : ifu_rdata, s_rdata);
        chk("rresp", 32'(m_who ? lsu_rresp : ifu_rresp), 32'(s_rresp));
      end
      if (s_rvalid && g_rready) n_busy = 0;
    end
    chk("handshakes",
        32'({ifu_arready, lsu_arready, clint_arvalid, mem_arvalid,
             ifu_rvalid, lsu_rvalid, clint_rready, mem_rready}),
        32'({acc_ifu, acc_lsu, e_carv, e_marv, e_irv, e_lrv, e_crr, e_mrr}));
    hs_ifu = ifu_arvalid && ifu_arready;
    hs_lsu = lsu_arvalid && lsu_arready;
    if (hs_ifu) grant_log.push_back(1'b0);
    if (hs_lsu) grant_log.push_back(1'b1);
    if (ifu_rvalid && ifu_rready) obs_resp[0]++;
    if (lsu_rvalid && lsu_rready) obs_resp[1]++;
    if (clint_arvalid) saw_clint = 1;
    if (mem_arvalid) saw_mem = 1;
    @(posedge clock);
    {m_busy, m_ar_done, m_who, m_clint, m_last, m_addr} =
      {n_busy, n_ar_done, n_who, n_clint, n_last, n_addr};
    #1;
    if (hs_ifu) begin
      ifu_arvalid = rand_mode ? 1'($urandom_range(0, 1)) : keep_valid;
      if (rand_mode) ifu_araddr = rand_addr();
    end
    if (hs_lsu) begin
      lsu_arvalid = rand_mode ? 1'($urandom_range(0, 1)) : keep_valid;
      if (rand_mode) lsu_araddr = rand_addr();
    end
    if (rand_mode && !ifu_arvalid && $urandom_range(0, 2) == 0) begin
      ifu_arvalid = 1; ifu_araddr = rand_addr();
    end
    if (rand_mode && !lsu_arvalid && $urandom_range(0, 2) == 0) begin
      lsu_arvalid = 1; lsu_araddr = rand_addr();
    end
  endtask

  task automatic slaves_ready();
    clint_arready = 1; clint_rvalid = 1; mem_arready = 1; mem_rvalid = 1;
    ifu_rready = 1; lsu_rready = 1;
  endtask

  task automatic do_reset();
    reset = 1;
    step();
    step();
    reset = 0;
  endtask

  task automatic ifu_decode(input string tag, input logic [31:0] a, input bit exp_clint);
    saw_clint = 0; saw_mem = 0;
    ifu_araddr = a; ifu_arvalid = 1;
    repeat (3) step();
    chk(tag, 32'({saw_clint, saw_mem}), 32'({exp_clint, !exp_clint}));
  endtask

  initial begin
    int r0;
    reset = 1;
    rand_mode = 0; keep_valid = 0;
    ifu_araddr = '0; ifu_arvalid = 0; ifu_rready = 0;
    lsu_araddr = '0; lsu_arvalid = 0; lsu_rready = 0;
    clint_arready = 0; clint_rvalid = 0; mem_arready = 0; mem_rvalid = 0;
    clint_rdata = '0; mem_rdata = '0; clint_rresp = '0; mem_rresp = '0;
    m_busy = 0; m_ar_done = 0; m_who = 0; m_clint = 0; m_last = 0; m_addr = '0;
    obs_resp[0] = 0; obs_resp[1] = 0;
    @(posedge clock);
    #1;
    do_reset();

    // IFU read from memory at minimum latency
    slaves_ready();
    ifu_araddr = 32'h8000_0000; ifu_arvalid = 1;
    saw_clint = 0; saw_mem = 0;
    repeat (3) step();
    chk("ifu_mem_resp", 32'(obs_resp[0]), 32'd1);
    chk("ifu_mem_no_clint", 32'(saw_clint), 32'd0);

    // LSU read routed to CLINT
    lsu_araddr = 32'h0200_BFF8; lsu_arvalid = 1;
    saw_clint = 0; saw_mem = 0;
    repeat (3) step();
    chk("lsu_clint_resp", 32'(obs_resp[1]), 32'd1);
    chk("lsu_clint_route", 32'({saw_clint, saw_mem}), 32'b10);
    chk("lsu_clint_ifu_quiet", 32'(obs_resp[0]), 32'd1);

    // Simultaneous requests held: grants alternate starting with LSU
    do_reset();
    grant_log.delete();
    keep_valid = 1;
    ifu_araddr = 32'h8000_0000; lsu_araddr = 32'h8000_0100;
    ifu_arvalid = 1; lsu_arvalid = 1;
    repeat (12) step();
    keep_valid = 0;
    ifu_arvalid = 0; lsu_arvalid = 0;
    chk("rr_count", 32'(grant_log.size()), 32'd4);
    if (grant_log.size() >= 4)
      chk("rr_order", 32'({grant_log[0], grant_log[1], grant_log[2], grant_log[3]}), 32'b1010);

    // CLINT stalls on AR and R, LSU back-pressures
    r0 = obs_resp[1];
    clint_arready = 0; clint_rvalid = 0; lsu_rready = 1;
    lsu_araddr = 32'h0200_0004; lsu_arvalid = 1;
    step();
    repeat (5) step();
    clint_arready = 1;
    step();
    clint_arready = 0;
    repeat (3) step();
    clint_rvalid = 1; lsu_rready = 0;
    repeat (2) step();
    lsu_rready = 1;
    step();
    clint_rvalid = 0;
    step();
    chk("stall_one_resp", 32'(obs_resp[1] - r0), 32'd1);

    // Reset while waiting for data, then a fresh IFU read
    slaves_ready();
    mem_rvalid = 0;
    ifu_araddr = 32'h8000_0040; ifu_arvalid = 1;
    step();
    step();
    r0 = obs_resp[0];
    mem_rvalid = 1;
    reset = 1;
    step();
    reset = 0;
    mem_rvalid = 0;
    step();
    chk("rst_abandon", 32'(obs_resp[0] - r0), 32'd0);
    mem_rvalid = 1;
    ifu_araddr = 32'h8000_0080; ifu_arvalid = 1;
    repeat (3) step();
    chk("post_rst_resp", 32'(obs_resp[0] - r0), 32'd1);

    // Decode boundaries
    ifu_decode("dec_02010000", 32'h0201_0000, 1'b0);
    ifu_decode("dec_01FFFFFC", 32'h01FF_FFFC, 1'b0);
    ifu_decode("dec_02000000", 32'h0200_0000, 1'b1);
    ifu_decode("dec_0200FFFC", 32'h0200_FFFC, 1'b1);

    // Random traffic
    rand_mode = 1;
    repeat (3000) step();
    rand_mode = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_23060236_rd_arbiter.md
# ysyx_23060236_rd_arbiter

Read-channel arbiter and address router between the two read requesters in the core, IFU and LSU, and two read slaves, the CLINT and the downstream memory/SoC port. Each requester exposes an AXI-lite-style read channel (AR plus R). The block grants one requester at a time using round-robin arbitration and routes the latched address to the CLINT or to memory by address decode. It returns the response only to the granted requester. Exactly one transaction is outstanding at any time.

## Interface
Parameters:
- CLINT_BASE, 32'h0200_0000, CLINT region base
- CLINT_MASK, 32'hFFFF_0000, decode mask; an address hits the CLINT iff (addr & CLINT_MASK) == CLINT_BASE

Ports:
- clock  in  1  single clock
- reset  in  1  synchronous, active-high
- ifu_araddr / lsu_araddr  in  32  requester read address
- ifu_arvalid / lsu_arvalid  in  1  requester address valid
- ifu_arready / lsu_arready  out  1  address accepted
- ifu_rdata / lsu_rdata  out  32  read data
- ifu_rresp / lsu_rresp  out  2  read response
- ifu_rvalid / lsu_rvalid  out  1  response valid
- ifu_rready / lsu_rready  in  1  requester ready for response
- clint_araddr / mem_araddr  out  32  slave address
- clint_arvalid / mem_arvalid  out  1  slave address valid
- clint_arready / mem_arready  in  1  slave address ready
- clint_rdata / mem_rdata  in  32  slave data
- clint_rresp / mem_rresp  in  2  slave response
- clint_rvalid / mem_rvalid  in  1  slave response valid
- clint_rready / mem_rready  out  1  slave response ready

## Operation
- States:
  - IDLE: waiting for a request.
  - ADDR: slave AR pending.
  - DATA: waiting for the R handshake.
- Registers:
  - state
  - grant (0=IFU, 1=LSU)
  - last_grant
  - sel (0=mem, 1=CLINT)
  - addr[31:0]
- Arbitration (IDLE only):
  - Only one arvalid high: that requester wins.
  - Both high: the requester not equal to last_grant wins.
  - The winner's arready is driven high combinationally in that cycle; the loser's arready stays 0.
- On acceptance:
  - addr <= winner araddr.
  - sel <= CLINT decode.
  - grant and last_grant <= winner.
  - state <= ADDR.
- ADDR:
  - The selected slave sees arvalid=1 and araddr=addr. The other slave sees arvalid=0 and araddr=addr (don't care).
  - On the selected slave's arready, go to DATA.
- DATA:
  - The selected slave's rdata, rresp and rvalid are forwarded to the granted requester.
  - The selected slave's rready equals the granted requester's rready.
  - The ungranted requester's rvalid is 0.
  - On rvalid & rready, go to IDLE.
- Both requester arready signals are 0 outside IDLE. A requester may hold arvalid and its address stable indefinitely while it waits.
- Slave rresp is passed through unchanged. No decode error is generated: every non-CLINT address goes to mem.

## Timing
- Reset values:
  - state=IDLE
  - last_grant=IFU, so the LSU wins the first tie
  - sel=0, grant=0, addr=0
  - All arready, arvalid, rvalid and rready outputs are 0 while reset is high.
- Minimum latency: accept in cycle N, slave AR handshake in N+1, R handshake in N+2, and a new accept is possible in N+3.
- Slave arready and rvalid may stall for any number of cycles; state holds and outputs stay stable.
- The response path is combinational from the slave to the requester. There is no buffering.
- A request arriving while not in IDLE waits. It is never dropped, never reordered with respect to its own channel, and never starved: round-robin guarantees a grant within one foreign transaction.
- Reset asserted mid-transaction:
  - Returns to IDLE next cycle and the in-flight transaction is abandoned.
  - The slaves are reset in the same cycle, so no stale rvalid is forwarded.
- Simultaneous arvalid in the same cycle as the R handshake completing: not accepted until the following IDLE cycle.

## Structure
- The shared defines header holds CLINT_BASE, CLINT_MASK, and the state encodings: IDLE=2'd0, ADDR=2'd1, DATA=2'd2.
- State, grant, last_grant, sel and addr are built with the existing ysyx_23060236_Reg register sub-module; the rest is combinational muxing.
- The decode function is a single shared expression, reused if a write arbiter is added later.

## Test plan
- Reset released, IFU reads 0x8000_0000 with mem arready/rvalid=1 -> ifu_arready pulses in cycle 0; mem_arvalid in cycle 1; ifu_rvalid with mem_rdata in cycle 2; clint_arvalid never 1.
- LSU reads 0x0200_BFF8 -> routed to CLINT only; lsu_rdata equals clint_rdata; ifu_rvalid stays 0.
- IFU and LSU assert arvalid together after reset -> LSU served first, then IFU; with both held, the grants alternate LSU, IFU, LSU, IFU.
- CLINT arready held low 5 cycles, then rvalid delayed 3 cycles with lsu_rready low 2 extra cycles:
  - state and address hold throughout.
  - clint_rready tracks lsu_rready.
  - Exactly one response is delivered.
- Reset asserted in DATA state -> next cycle in IDLE with all valids 0; a fresh IFU request then completes normally.
- Boundary decode: 0x0201_0000 and 0x01FF_FFFC go to mem; 0x0200_0000 and 0x0200_FFFC go to CLINT.
